// File: rtl/pcm_sink_pkg.sv
// +--------------------------------------------------------------------------+
// | pcm_sink_pkg                                                             |
// | Shared widths, constants and types for the PCM stream PWM sink.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package pcm_sink_pkg;

  localparam int PCM_W = 8;
  localparam int PWM_PERIOD = 256;
  localparam logic [PCM_W-1:0] PCM_MIDSCALE = 8'h80;

  typedef logic [PCM_W-1:0] pcm_t;

endpackage : pcm_sink_pkg

`default_nettype wire

// File: rtl/pcm_sink_fifo.sv
// +--------------------------------------------------------------------------+
// | pcm_sink_fifo                                                            |
// | Power-of-two sample FIFO; head is visible on 'head' while not empty.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pcm_sink_fifo
  import pcm_sink_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  pcm_t                     push_data,
  input  logic                     pop,
  output pcm_t                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  pcm_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  logic w_push;
  logic w_pop;

  assign full  = (r_level == C_DEPTH);
  assign empty = (r_level == '0);
  assign level = r_level;
  assign head  = r_mem[r_rd_ptr];

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule : pcm_sink_fifo

`default_nettype wire

// File: rtl/pcm_stream_pwm_sink.sv
// +--------------------------------------------------------------------------+
// | pcm_stream_pwm_sink                                                      |
// | Buffers 8-bit PCM samples and plays each as a 256-cycle PWM duty for     |
// | PERIODS_PER_SAMPLE periods. Optional underrun counter: define            |
// | PCM_SINK_UNDERRUN_CNT_EN.                                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pcm_stream_pwm_sink
  import pcm_sink_pkg::*;
#(
  parameter int FIFO_DEPTH         = 4,
  parameter int PERIODS_PER_SAMPLE = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  pcm_t                          pcm_in,
  input  logic                          pcm_in_vld,
  output logic                          pcm_in_rdy,
  output logic                          pwm_out,
  output logic                          sample_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_count
);

  localparam int CW = $clog2(PWM_PERIOD);
  localparam logic [7:0] C_PERIOD_MAX = 8'(PERIODS_PER_SAMPLE - 1);

  logic [CW-1:0] r_pwm_cnt;
  logic [7:0]    r_period_cnt;
  pcm_t          r_active;

  pcm_t                         w_head;
  logic                         w_full;
  logic                         w_empty;
  logic [$clog2(FIFO_DEPTH):0]  w_level;
  logic                         w_slot_end;
  logic                         w_push;
  logic                         w_pop;

  assign w_slot_end = (r_pwm_cnt == '1) && (r_period_cnt == C_PERIOD_MAX);
  assign w_push     = pcm_in_vld && pcm_in_rdy;
  assign w_pop      = w_slot_end && !w_empty && !reset;

  pcm_sink_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (pcm_in),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (w_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm_cnt    <= '0;
      r_period_cnt <= '0;
      r_active     <= PCM_MIDSCALE;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == '1) begin
        r_period_cnt <= w_slot_end ? 8'd0 : r_period_cnt + 8'd1;
      end
      if (w_pop) begin
        r_active <= w_head;
      end
    end
  end

  // Outputs are forced quiet while reset is high, including its first cycle.
  assign pcm_in_rdy  = !reset && !w_full;
  assign pwm_out     = !reset && (r_pwm_cnt < r_active);
  assign sample_tick = !reset && w_slot_end;
  assign underrun    = sample_tick && w_empty;
  assign fifo_level  = reset ? '0 : w_level;

`ifdef PCM_SINK_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_underrun_count <= '0;
    end else if (underrun && (r_underrun_count != 16'hFFFF)) begin
      r_underrun_count <= r_underrun_count + 16'd1;
    end
  end

  assign underrun_count = r_underrun_count;
`else
  assign underrun_count = 16'h0000;
`endif

endmodule : pcm_stream_pwm_sink

`default_nettype wire

// File: tb/tb_pcm_stream_pwm_sink.sv
// +--------------------------------------------------------------------------+
// | tb_pcm_stream_pwm_sink                                                   |
// | Directed testbench for pcm_stream_pwm_sink (default and 3-period build). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pcm_stream_pwm_sink;

  logic        clk;
  logic        reset;
  logic [7:0]  pcm_in;
  logic        pcm_in_vld;
  logic        pcm_in_rdy;
  logic        pwm_out;
  logic        sample_tick;
  logic        underrun;
  logic [2:0]  fifo_level;
  logic [15:0] underrun_count;

  logic [7:0]  pcm_in3;
  logic        pcm_in_vld3;
  logic        pcm_in_rdy3;
  logic        pwm_out3;
  logic        sample_tick3;
  logic        underrun3;
  logic [2:0]  fifo_level3;
  logic [15:0] underrun_count3;

  int checks;
  int errors;

  pcm_stream_pwm_sink dut (
    .clk            (clk),
    .reset          (reset),
    .pcm_in         (pcm_in),
    .pcm_in_vld     (pcm_in_vld),
    .pcm_in_rdy     (pcm_in_rdy),
    .pwm_out        (pwm_out),
    .sample_tick    (sample_tick),
    .underrun       (underrun),
    .fifo_level     (fifo_level),
    .underrun_count (underrun_count)
  );

  pcm_stream_pwm_sink #(
    .FIFO_DEPTH         (4),
    .PERIODS_PER_SAMPLE (3)
  ) dut3 (
    .clk            (clk),
    .reset          (reset),
    .pcm_in         (pcm_in3),
    .pcm_in_vld     (pcm_in_vld3),
    .pcm_in_rdy     (pcm_in_rdy3),
    .pwm_out        (pwm_out3),
    .sample_tick    (sample_tick3),
    .underrun       (underrun3),
    .fifo_level     (fifo_level3),
    .underrun_count (underrun_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the caller at the negedge where reset drops: cycle 0, counters at 0.
  task automatic do_reset();
    reset       = 1'b1;
    pcm_in_vld  = 1'b0;
    pcm_in_vld3 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Samples n consecutive cycles (current one first) and tallies activity.
  task automatic measure(input bit sel, input int n, output int high, output int ticks,
                         output int unders, output int accepts, output int max_lvl);
    high = 0; ticks = 0; unders = 0; accepts = 0; max_lvl = 0;
    for (int i = 0; i < n; i++) begin
      if (!sel) begin
        if (pwm_out) high++;
        if (sample_tick) ticks++;
        if (underrun) unders++;
        if (pcm_in_vld && pcm_in_rdy) accepts++;
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      end else begin
        if (pwm_out3) high++;
        if (sample_tick3) ticks++;
        if (underrun3) unders++;
        if (pcm_in_vld3 && pcm_in_rdy3) accepts++;
        if (int'(fifo_level3) > max_lvl) max_lvl = int'(fifo_level3);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pcm_in_vld = 1'b0;
    pcm_in_vld3 = 1'b0;
    pcm_in = 8'h00;
    pcm_in3 = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({pcm_in_rdy, pwm_out, sample_tick, underrun, fifo_level, underrun_count} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b pwm=%b tick=%b und=%b lvl=%0d cnt=%0d required all 0",
               pcm_in_rdy, pwm_out, sample_tick, underrun, fifo_level, underrun_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (pcm_in_rdy !== 1'b1 || fifo_level !== 3'd0 || pwm_out !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: rdy=%b lvl=%0d pwm=%b required rdy=1 lvl=0 pwm=1",
               pcm_in_rdy, fifo_level, pwm_out);
    end
  endtask

  task automatic test_idle();
    int h, t, u, a, m;
    int exp_cnt;
    do_reset();
    for (int w = 0; w < 2; w++) begin
      measure(1'b0, 256, h, t, u, a, m);
      checks++;
      if (h != 128 || t != 1 || u != 1) begin
        errors++;
        $display("FAIL idle_window%0d: high=%0d ticks=%0d unders=%0d required 128/1/1", w, h, t, u);
      end
    end
`ifdef PCM_SINK_UNDERRUN_CNT_EN
    exp_cnt = 2;
`else
    exp_cnt = 0;
`endif
    checks++;
    if (int'(underrun_count) != exp_cnt) begin
      errors++;
      $display("FAIL idle_underrun_count: got %0d required %0d", underrun_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int h, t, u, a, m;
    logic [7:0] vals [3];
    int exp_high [3];
    vals = '{8'h00, 8'hFF, 8'h40};
    exp_high = '{0, 255, 64};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pcm_in = vals[i];
      pcm_in_vld = 1'b1;
      checks++;
      if (pcm_in_rdy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_rdy%0d: got %b required 1", i, pcm_in_rdy);
      end
      @(negedge clk);
      #1;
    end
    pcm_in_vld = 1'b0;
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL b2b_level: got %0d required 3", fifo_level);
    end
    measure(1'b0, 253, h, t, u, a, m);
    checks++;
    if (t != 1 || u != 0) begin
      errors++;
      $display("FAIL b2b_first_slot: ticks=%0d unders=%0d required 1/0", t, u);
    end
    for (int s = 0; s < 3; s++) begin
      measure(1'b0, 256, h, t, u, a, m);
      checks++;
      if (h != exp_high[s] || t != 1 || u != ((s == 2) ? 1 : 0)) begin
        errors++;
        $display("FAIL b2b_slot%0d: high=%0d ticks=%0d unders=%0d required %0d/1/%0d",
                 s, h, t, u, exp_high[s], (s == 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_full();
    int h, t, u, a, m;
    do_reset();
    pcm_in = 8'h55;
    pcm_in_vld = 1'b1;
    measure(1'b0, 4, h, t, u, a, m);
    checks++;
    if (a != 4) begin
      errors++;
      $display("FAIL full_accepts: got %0d required 4", a);
    end
    checks++;
    if (pcm_in_rdy !== 1'b0 || fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL full_state: rdy=%b lvl=%0d required rdy=0 lvl=4", pcm_in_rdy, fifo_level);
    end
    measure(1'b0, 252, h, t, u, a, m);
    checks++;
    if (a != 0 || t != 1 || m != 4) begin
      errors++;
      $display("FAIL full_hold: accepts=%0d ticks=%0d maxlvl=%0d required 0/1/4", a, t, m);
    end
    measure(1'b0, 256, h, t, u, a, m);
    checks++;
    if (a != 1 || t != 1 || m != 4 || u != 0) begin
      errors++;
      $display("FAIL full_refill: accepts=%0d ticks=%0d maxlvl=%0d unders=%0d required 1/1/4/0",
               a, t, m, u);
    end
    pcm_in_vld = 1'b0;
  endtask

  task automatic test_pps3();
    int h, t, u, a, m;
    do_reset();
    pcm_in3 = 8'h20;
    pcm_in_vld3 = 1'b1;
    @(negedge clk);
    #1;
    pcm_in_vld3 = 1'b0;
    measure(1'b1, 767, h, t, u, a, m);
    checks++;
    if (t != 1 || u != 0 || h != 3 * 128 - 1) begin
      errors++;
      $display("FAIL pps3_first_slot: ticks=%0d unders=%0d high=%0d required 1/0/383", t, u, h);
    end
    for (int p = 0; p < 3; p++) begin
      measure(1'b1, 256, h, t, u, a, m);
      checks++;
      if (h != 32 || t != ((p == 2) ? 1 : 0)) begin
        errors++;
        $display("FAIL pps3_period%0d: high=%0d ticks=%0d required 32/%0d",
                 p, h, t, (p == 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int h, t, u, a, m;
    do_reset();
    pcm_in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pcm_in = 8'h10 + 8'(i * 8'h30);
      @(negedge clk);
      #1;
    end
    pcm_in_vld = 1'b0;
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL mid_level_before: got %0d required 3", fifo_level);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (fifo_level !== 3'd0 || pwm_out !== 1'b0 || pcm_in_rdy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: lvl=%0d pwm=%b rdy=%b required 0/0/0",
               fifo_level, pwm_out, pcm_in_rdy);
    end
    measure(1'b0, 300, h, t, u, a, m);
    checks++;
    if (h != 0 || t != 0 || u != 0 || m != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: high=%0d ticks=%0d unders=%0d maxlvl=%0d required all 0",
               h, t, u, m);
    end
    reset = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      measure(1'b0, 256, h, t, u, a, m);
      checks++;
      if (h != 128 || u != 1) begin
        errors++;
        $display("FAIL mid_resume%0d: high=%0d unders=%0d required 128/1", w, h, u);
      end
    end
  endtask

  task automatic test_boundary_push();
    int h, t, u, a, m;
    do_reset();
    repeat (255) begin
      @(negedge clk);
      #1;
    end
    pcm_in = 8'hC0;
    pcm_in_vld = 1'b1;
    checks++;
    if (sample_tick !== 1'b1 || underrun !== 1'b1 || pcm_in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL bnd_push_cycle: tick=%b und=%b rdy=%b required 1/1/1",
               sample_tick, underrun, pcm_in_rdy);
    end
    @(negedge clk);
    #1;
    pcm_in_vld = 1'b0;
    checks++;
    if (fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL bnd_stored: lvl=%0d required 1", fifo_level);
    end
    measure(1'b0, 256, h, t, u, a, m);
    checks++;
    if (h != 128 || u != 0) begin
      errors++;
      $display("FAIL bnd_hold_slot: high=%0d unders=%0d required 128/0", h, u);
    end
    measure(1'b0, 256, h, t, u, a, m);
    checks++;
    if (h != 192) begin
      errors++;
      $display("FAIL bnd_play_slot: high=%0d required 192", h);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_idle();
    test_back_to_back();
    test_full();
    test_pps3();
    test_reset_mid();
    test_boundary_push();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_pcm_stream_pwm_sink

`default_nettype wire

// File: doc/pcm_stream_pwm_sink.md
PCM_STREAM_PWM_SINK -- requirements
Module: pcm_stream_pwm_sink

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, sample FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter PERIODS_PER_SAMPLE, default 1, PWM periods each sample is held (1..255).
REQ-003 SHALL have a single clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port pcm_in, input, 8, unsigned PCM sample from the bytebeat stream.
REQ-007 SHALL have port pcm_in_vld, input, 1, pcm_in valid.
REQ-008 SHALL have port pcm_in_rdy, output, 1, sink can accept a sample this cycle.
REQ-009 SHALL have port pwm_out, output, 1, PWM audio bit.
REQ-010 SHALL have port sample_tick, output, 1, one-cycle pulse when a new sample slot starts.
REQ-011 SHALL have port underrun, output, 1, one-cycle pulse when a slot starts with the FIFO empty.
REQ-012 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
REQ-013 SHALL have port underrun_count, output, 16, underrun event count (see Configuration).

Function
REQ-014 SHALL transfer a sample only on a cycle where pcm_in_vld and pcm_in_rdy are both 1.
REQ-015 SHALL drive pcm_in_rdy = (fifo_level < FIFO_DEPTH) from registers only; no combinational path from pcm_in_vld.
REQ-016 SHALL run an 8-bit PWM counter, incrementing every cycle and wrapping 255->0 (256-cycle period).
REQ-017 SHALL run a period counter 0..PERIODS_PER_SAMPLE-1, advancing when the PWM counter wraps; a slot boundary is the cycle where the PWM counter is 255 and the period counter is at its maximum.
REQ-018 At a slot boundary: pulse sample_tick; if FIFO non-empty, pop the head into the active-sample register, effective from the next cycle (PWM counter 0); if empty, keep the active sample and pulse underrun.
REQ-019 SHALL drive pwm_out = (pwm_counter < active_sample), with both operands registered: 0 gives always-low, 255 gives high for 255 of 256 cycles.
REQ-020 SHALL preserve FIFO order; no sample is dropped or duplicated.
REQ-021 Push and pop in the same cycle SHALL leave fifo_level unchanged and both take effect.
REQ-022 With the FIFO full, pcm_in_rdy SHALL be 0 even on a pop cycle (no same-cycle bypass).
REQ-023 With the FIFO empty, a push on a boundary cycle SHALL NOT be popped that cycle: underrun pulses and the sample is stored.
REQ-024 Transfer to pwm_out latency: a sample pushed into an empty FIFO SHALL drive pwm_out from the cycle after the next slot boundary.

Reset
REQ-025 While reset is 1: pcm_in_rdy=0, pwm_out=0, sample_tick=0, underrun=0, fifo_level=0, underrun_count=0.
REQ-026 After reset: PWM and period counters=0, active_sample=8'h80 (mid-scale), FIFO empty, pcm_in_rdy=1 on the first cycle after reset deasserts.
REQ-027 Reset asserted mid-operation SHALL discard FIFO contents and any in-progress period without emitting tick or underrun pulses.

Configuration
REQ-028 With PCM_SINK_UNDERRUN_CNT_EN defined, underrun_count SHALL increment on each underrun pulse, saturating at 16'hFFFF.
REQ-029 Without PCM_SINK_UNDERRUN_CNT_EN, underrun_count SHALL be tied to 0 and no counter logic is instantiated.

Structure
REQ-030 Package pcm_sink_pkg SHALL hold PCM_W=8, PWM_PERIOD=256, PCM_MIDSCALE=8'h80 and typedef pcm_t (8-bit logic).
REQ-031 The FIFO SHALL be a sub-module pcm_sink_fifo (push/pop/full/empty/level, parameter DEPTH), instantiated once.

Verification
REQ-032 Reset then idle with vld=0 -> pwm_out high for exactly 128 of each 256 cycles; underrun pulses every 256 cycles; underrun_count increments (macro on), stays 0 (macro off).
REQ-033 Push 8'h00, 8'hFF, 8'h40 back to back with default parameters -> successive slots show 0, 255 and 64 high cycles per 256-cycle period, no underrun while the FIFO has data.
REQ-034 Hold vld=1 continuously -> rdy drops after 4 accepts; thereafter exactly one accept follows each sample_tick; fifo_level never exceeds 4.
REQ-035 Set PERIODS_PER_SAMPLE=3 and push 8'h20 -> pwm_out is high for 32 cycles in each of 3 consecutive 256-cycle periods, with sample_tick every 768 cycles.
REQ-036 Assert reset mid-stream with the FIFO at 3 -> fifo_level=0 and pwm_out=0 during reset; after release the 50% duty mid-scale output resumes and the old samples never appear.
REQ-037 Push into an empty FIFO on the exact boundary cycle -> underrun pulses that cycle, and the sample appears on pwm_out from the following boundary.
